// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// lane widths and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        ERR
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Size 11 is never a legal access, whatever the address.
    function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges sub-word store data into a memory word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e              size,
    input  logic               is_unsigned,
    input  logic [1:0]         lane,
    input  logic [WORD_W-1:0]  mem_word,
    input  logic [WORD_W-1:0]  store_data,
    output logic [WORD_W-1:0]  load_data,
    output logic [WORD_W-1:0]  merged_word
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [BYTE_W-1:0] byte_val;
    logic [HALF_W-1:0] half_val;

    assign byte_sh  = {lane, 3'b000};
    assign half_sh  = {lane[1], 4'b0000};
    assign byte_val = mem_word[byte_sh +: BYTE_W];
    assign half_val = mem_word[half_sh +: HALF_W];

    always_comb begin
        load_data   = mem_word;
        merged_word = store_data;
        case (size)
            SZ_B: begin
                load_data = {{(WORD_W-BYTE_W){~is_unsigned & byte_val[BYTE_W-1]}}, byte_val};
                merged_word = mem_word;
                merged_word[byte_sh +: BYTE_W] = store_data[BYTE_W-1:0];
            end
            SZ_H: begin
                load_data = {{(WORD_W-HALF_W){~is_unsigned & half_val[HALF_W-1]}}, half_val};
                merged_word = mem_word;
                merged_word[half_sh +: HALF_W] = store_data[HALF_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator for the single-cycle core: one request at a time,
// sub-word stores done as read-modify-write on a memory without byte enables.
//
// state  | meaning
// IDLE   | ready for a request; response pulse of the previous one shows here
// LOAD   | read word, extract lane, register extended result
// STORE  | full-word write, one cycle
// RMW_RD | read target word into the merge register
// RMW_WR | write merged word, one cycle
// ERR    | rejected access; error response is visible in this cycle
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [DATA_WIDTH:0] ADDR_LIMIT = (DATA_WIDTH+1)'(4 * MEM_WORDS);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    size_e                 size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  req_bad;
    logic [DATA_WIDTH-1:0] align_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign req_bad = access_misaligned(req_size, req_addr[1:0])
                   || ({1'b0, req_addr} >= ADDR_LIMIT);

    // The merge register holds the word read in RMW_RD; LOAD uses the live read.
    assign align_word = (state_q == LOAD) ? mem_rd : merge_q;

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (addr_q[1:0]),
        .mem_word    (align_word),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        // Error answers one cycle after acceptance, without touching memory.
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_size == SZ_W) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = IDLE;
            end
            STORE: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RMW_RD: begin
                merge_d = mem_rd;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Write strobe decoded from the state so it drops the moment reset asserts.
    always_comb begin
        mem_we = 1'b0;
        mem_wd = '0;
        case (state_q)
            STORE: begin
                mem_we = 1'b1;
                mem_wd = wdata_q;
            end
            RMW_WR: begin
                mem_we = 1'b1;
                mem_wd = merged_word;
            end
            default: ;
        endcase
    end

    assign mem_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a word-array reference model predicts
// every response and memory write, checked by one monitor on each falling edge.
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        int          nwe;
        logic [31:0] wd;
        logic [31:0] waddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

    logic [31:0] tb_mem  [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    exp_t        expq[$];

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          we_seen = 0;
    int          acc_cyc = 0;
    int          last_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    load_store_unit #(.DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd = tb_mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[11:2]] <= mem_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics of one accepted request; updates the model memory.
    task automatic model_accept(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input int n, output exp_t e);
        int          nbytes, sh;
        logic [31:0] word, mask, val;
        e.nwe = 0; e.rdata = '0; e.err = 1'b0; e.wd = '0;
        e.waddr = addr & ~32'd3;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (addr % nbytes) != 0 || addr >= 32'(4 * MEM_WORDS)) begin
            e.err = 1'b1;
            e.due = n + 1;
            return;
        end
        word = ref_mem[addr / 4];
        sh   = int'(addr % 4) * 8;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nbytes * 8)) - 32'd1);
        if (!we) begin
            val = (word >> sh) & mask;
            if (!uns && nbytes < 4 && val[nbytes*8-1]) val = val | ~mask;
            e.rdata = val;
            e.due   = n + 2;
        end else begin
            val = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[addr / 4] = val;
            e.nwe = 1;
            e.wd  = val;
            e.due = n + ((nbytes == 4) ? 2 : 3);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                model_accept(we, sz, uns, addr, wd, cyc, e);
                expq.push_back(e);
                acc_cyc = cyc;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            chk("drain_timeout", 32'(expq.size()), 32'd0);
            expq.delete();
            we_seen = 0;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (expq.size() > 0 && cyc > expq[0].due) begin
                chk("resp_timeout", 32'(cyc), 32'(expq[0].due));
                void'(expq.pop_front());
                we_seen = 0;
            end
            chk("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            if (mem_we) begin
                if (expq.size() == 0) begin
                    chk("spurious_mem_we", {31'd0, mem_we}, 32'd0);
                end else begin
                    chk("mem_we_allowed", 32'(we_seen), 32'(expq[0].nwe - 1));
                    chk("mem_we_cycle", 32'(cyc), 32'(expq[0].due - 1));
                    chk("mem_wd", mem_wd, expq[0].wd);
                    chk("mem_we_addr", mem_addr, expq[0].waddr);
                    we_seen++;
                end
            end
            if (resp_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_resp", {31'd0, resp_valid}, 32'd0);
                end else begin
                    chk("resp_cycle", 32'(cyc), 32'(expq[0].due));
                    chk("resp_rdata", resp_rdata, expq[0].rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, expq[0].err});
                    chk("mem_we_count", 32'(we_seen), 32'(expq[0].nwe));
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                    last_cyc   = cyc;
                    void'(expq.pop_front());
                    we_seen = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] saved, first_acc;
        logic [31:0] addr;
        logic [1:0]  sz;
        for (int i = 0; i < MEM_WORDS; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[4] = 32'h8765_4321; ref_mem[4] = 32'h8765_4321;
        tb_mem[2] = 32'hAABB_CCDD; ref_mem[2] = 32'hAABB_CCDD;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        send(1'b0, 2'd2, 1'b0, 32'h10, 32'd0); idle(1); drain();
        chk("lw_data", last_rdata, 32'h8765_4321);
        chk("lw_latency", 32'(last_cyc - acc_cyc), 32'd2);
        send(1'b0, 2'd0, 1'b0, 32'h13, 32'd0); idle(1); drain();
        chk("lb_data", last_rdata, 32'hFFFF_FF87);
        send(1'b0, 2'd0, 1'b1, 32'h13, 32'd0); idle(1); drain();
        chk("lbu_data", last_rdata, 32'h0000_0087);
        send(1'b0, 2'd1, 1'b0, 32'h12, 32'd0); idle(1); drain();
        chk("lh_data", last_rdata, 32'hFFFF_8765);

        send(1'b1, 2'd0, 1'b0, 32'h09, 32'h11); idle(1); drain();
        chk("sb_mem", tb_mem[2], 32'hAABB_11DD);
        chk("sb_latency", 32'(last_cyc - acc_cyc), 32'd3);
        send(1'b1, 2'd1, 1'b0, 32'h0A, 32'hBEEF); idle(1); drain();
        chk("sh_mem", tb_mem[2], 32'hBEEF_11DD);

        send(1'b0, 2'd2, 1'b0, 32'h06, 32'd0); idle(1); drain();
        chk("lw_mis_err", {31'd0, last_err}, 32'd1);
        chk("err_latency", 32'(last_cyc - acc_cyc), 32'd1);
        send(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234); idle(1); drain();
        chk("sh_mis_err", {31'd0, last_err}, 32'd1);
        chk("sh_mis_mem", tb_mem[0], ref_mem[0]);
        send(1'b0, 2'd3, 1'b0, 32'h00, 32'd0); idle(1); drain();
        chk("size11_err", {31'd0, last_err}, 32'd1);
        send(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEAD_BEEF); idle(1); drain();
        chk("range_err", {31'd0, last_err}, 32'd1);
        chk("range_rdata", last_rdata, 32'd0);

        send(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D);
        first_acc = 32'(acc_cyc);
        send(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        chk("b2b_accept", 32'(acc_cyc), first_acc + 32'd2);
        idle(1); drain();
        chk("b2b_data", last_rdata, 32'hCAFE_F00D);

        saved = tb_mem[5];
        send(1'b1, 2'd0, 1'b0, 32'h15, 32'h5A);
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mem_wd", mem_wd, 32'd0);
        expq.delete();
        we_seen = 0;
        ref_mem[5] = saved;
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("mid_rst_word", tb_mem[5], saved);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int t = 0; t < 400; t++) begin
            case ($urandom % 16)
                0:       addr = 32'hFFC + ($urandom % 8);
                1:       addr = $urandom;
                default: addr = $urandom_range(0, 63);
            endcase
            sz = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
            send(1'($urandom), sz, 1'($urandom), addr, $urandom);
            if (($urandom % 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
